alu_muldiv: RTL and testbench

- Multi-cycle multiply/divide companion to the combinational MIPS150 ALU.
- Executes MULT, MULTU, DIV and DIVU on WIDTH-bit operands into HI/LO result registers, using an iterative shift-add multiplier and a restoring divider (one bit per cycle).
- Sits beside the single-cycle ALU in the execute stage. The pipeline issues `start` and stalls on `busy`; MFHI/MFLO read `hi`/`lo`, and MTHI/MTLO write them.

---
 rtl/alu_muldiv.sv | 141 ++++++++++++++
 tb/tb_alu_muldiv.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit beside the single-cycle ALU: shift-add multiply and
// restoring divide, one bit per cycle, results land in the HI/LO registers.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [CW-1:0]        CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]        CNT_ONE  = 1;
  localparam logic [WIDTH-1:0]     ONE_W    = 1;
  localparam logic [2*WIDTH-1:0]   ONE_2W   = 1;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_done, r_dbz;
  logic [WIDTH-1:0] r_hi, r_lo;

  logic             r_op_div, r_sgn_q, r_sgn_r, r_dz;
  logic [WIDTH-1:0] r_a, r_ma, r_ph, r_pl;

  logic [WIDTH:0]     w_sum, w_shr, w_trial;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;

  function automatic logic [WIDTH-1:0] f_neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + ONE_W) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] f_neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? (~v + ONE_2W) : v;
  endfunction

  // r_ma holds |multiplicand| or |divisor|; r_pl starts as |multiplier| or |dividend|.
  always_comb begin
    w_sum   = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_ma} : {(WIDTH+1){1'b0}});
    w_shr   = {r_ph, r_pl[WIDTH-1]};
    w_trial = w_shr - {1'b0, r_ma};
    w_prod  = f_neg_2w({r_ph, r_pl}, r_sgn_q);
    w_quo   = f_neg_w(r_pl, r_sgn_q);
    w_rem   = f_neg_w(r_ph, r_sgn_r);
  end

  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start) begin
      r_op_div <= op[1];
      r_sgn_q  <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
      r_sgn_r  <= op[0] & a[WIDTH-1];
      r_dz     <= op[1] & (b == '0);
      r_a      <= a;
      r_ph     <= '0;
      if (op[1]) begin
        r_ma <= f_neg_w(b, op[0] & b[WIDTH-1]);
        r_pl <= f_neg_w(a, op[0] & a[WIDTH-1]);
      end else begin
        r_ma <= f_neg_w(a, op[0] & a[WIDTH-1]);
        r_pl <= f_neg_w(b, op[0] & b[WIDTH-1]);
      end
    end else if (r_state == S_RUN) begin
      if (!r_op_div) begin
        r_ph <= w_sum[WIDTH:1];
        r_pl <= {w_sum[0], r_pl[WIDTH-1:1]};
      end else if (!w_trial[WIDTH]) begin
        r_ph <= w_trial[WIDTH-1:0];
        r_pl <= {r_pl[WIDTH-2:0], 1'b1};
      end else begin
        r_ph <= w_shr[WIDTH-1:0];
        r_pl <= {r_pl[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_cnt   <= CNT_INIT;
          end else begin
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) r_state <= S_FIX;
        end
        S_FIX: begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
          r_dbz   <= r_dz;
          if (!r_op_div) begin
            {r_hi, r_lo} <= w_prod;
          end else if (r_dz) begin
            // Divide by zero reports the untouched dividend, not its magnitude.
            r_hi <= r_a;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv at WIDTH=32 and WIDTH=8.
module tb_alu_muldiv;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  logic        start8, mthi8, mtlo8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wdata8;
  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;

  int total = 0;
  int bad   = 0;

  alu_muldiv #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(dbz), .hi(hi), .lo(lo)
  );

  alu_muldiv #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .mthi(mthi8), .mtlo(mtlo8), .wdata(wdata8), .busy(busy8), .done(done8),
    .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
  );

  // Issue one op in the current cycle and wait for done; lat counts cycles from the accept edge.
  task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int bc, output logic chg);
    logic [31:0] h1, l1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    h1 = hi; l1 = lo; chg = 1'b0;
    lat = 1; bc = 0;
    while (!done && lat < 100) begin
      if (busy) bc++;
      if (hi !== h1 || lo !== l1) chg = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                      output int lat, output int bc);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 1; bc = 0;
    while (!done8 && lat < 100) begin
      if (busy8) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, dbz} !== 3'b000 || hi !== 32'h0 || lo !== 32'h0) begin
      bad++; $display("FAIL reset32 got busy/done/dbz=%b hi=%h lo=%h want 000 0 0", {busy, done, dbz}, hi, lo);
    end
    total++;
    if ({busy8, done8, dbz8} !== 3'b000 || hi8 !== 8'h0 || lo8 !== 8'h0) begin
      bad++; $display("FAIL reset8 got busy/done/dbz=%b hi=%h lo=%h want 000 0 0", {busy8, done8, dbz8}, hi8, lo8);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_multu();
    int lat, bc; logic chg;
    run32(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc, chg);
    total++;
    if (lat !== 34 || bc !== 33 || busy !== 1'b0) begin
      bad++; $display("FAIL multu_timing got lat=%0d busycycles=%0d busy=%b want 34 33 0", lat, bc, busy);
    end
    total++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001 || dbz !== 1'b0 || chg !== 1'b0) begin
      bad++; $display("FAIL multu got hi=%h lo=%h dbz=%b chg=%b want fffffffe 00000001 0 0", hi, lo, dbz, chg);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL done_pulse got done=%b want 0", done);
    end
  endtask

  task automatic test_mult();
    int lat, bc; logic chg;
    run32(2'b01, 32'hFFFFFFFD, 32'd7, lat, bc, chg);
    total++;
    if (lat !== 34 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
      bad++; $display("FAIL mult_neg got lat=%0d hi=%h lo=%h want 34 ffffffff ffffffeb", lat, hi, lo);
    end
    run32(2'b01, 32'h0, 32'hFFFFFFFB, lat, bc, chg);
    total++;
    if (lat !== 34 || hi !== 32'h0 || lo !== 32'h0) begin
      bad++; $display("FAIL mult_zero got lat=%0d hi=%h lo=%h want 34 0 0", lat, hi, lo);
    end
  endtask

  task automatic test_div();
    int lat, bc; logic chg;
    run32(2'b11, 32'hFFFFFFF9, 32'd2, lat, bc, chg);
    total++;
    if (lat !== 34 || lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF || dbz !== 1'b0) begin
      bad++; $display("FAIL div_neg got lat=%0d lo=%h hi=%h dbz=%b want 34 fffffffd ffffffff 0", lat, lo, hi, dbz);
    end
    run32(2'b10, 32'd100, 32'd7, lat, bc, chg);
    total++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      bad++; $display("FAIL divu got lo=%h hi=%h want 0000000e 00000002", lo, hi);
    end
    run32(2'b11, 32'd7, 32'hFFFFFFFE, lat, bc, chg);
    total++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'd1) begin
      bad++; $display("FAIL div_negdivisor got lo=%h hi=%h want fffffffd 00000001", lo, hi);
    end
    run32(2'b11, 32'h80000000, 32'hFFFFFFFF, lat, bc, chg);
    total++;
    if (lo !== 32'h80000000 || hi !== 32'h0 || dbz !== 1'b0) begin
      bad++; $display("FAIL div_ovf got lo=%h hi=%h dbz=%b want 80000000 0 0", lo, hi, dbz);
    end
  endtask

  task automatic test_div_by_zero();
    int lat, bc; logic chg;
    run32(2'b10, 32'h1234, 32'h0, lat, bc, chg);
    total++;
    if (lat !== 34 || dbz !== 1'b1 || lo !== 32'hFFFFFFFF || hi !== 32'h00001234) begin
      bad++; $display("FAIL divu_zero got lat=%0d dbz=%b lo=%h hi=%h want 34 1 ffffffff 00001234", lat, dbz, lo, hi);
    end
    run32(2'b11, 32'hFFFFFFF9, 32'h0, lat, bc, chg);
    total++;
    if (dbz !== 1'b1 || lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFF9) begin
      bad++; $display("FAIL div_zero got dbz=%b lo=%h hi=%h want 1 ffffffff fffffff9", dbz, lo, hi);
    end
    @(posedge clk); #1;
    total++;
    if (dbz !== 1'b0) begin
      bad++; $display("FAIL dbz_pulse got dbz=%b want 0", dbz);
    end
  endtask

  task automatic test_mthi_mtlo();
    int lat; int seen;
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5A;
    @(posedge clk); #1;
    total++;
    if (hi !== 32'h5A || lo !== 32'h5A) begin
      bad++; $display("FAIL mt_both got hi=%h lo=%h want 5a 5a", hi, lo);
    end
    mthi = 1'b1; mtlo = 1'b0; wdata = 32'h11;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b1; wdata = 32'h22;
    @(posedge clk); #1;
    mtlo = 1'b0; mthi = 1'b1; wdata = 32'hAA;
    @(posedge clk); #1;
    mthi = 1'b0;
    total++;
    if (hi !== 32'hAA || lo !== 32'h22) begin
      bad++; $display("FAIL mthi got hi=%h lo=%h want aa 22", hi, lo);
    end
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    mtlo = 1'b1; wdata = 32'hBB; start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    mtlo = 1'b0; start = 1'b0;
    total++;
    if (lo !== 32'h22 || hi !== 32'hAA || busy !== 1'b1) begin
      bad++; $display("FAIL busy_ignore got lo=%h hi=%h busy=%b want 22 aa 1", lo, hi, busy);
    end
    lat = 6;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat !== 34 || hi !== 32'h0 || lo !== 32'd15) begin
      bad++; $display("FAIL first_only got lat=%0d hi=%h lo=%h want 34 0 0000000f", lat, hi, lo);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL no_queue got activecycles=%0d want 0", seen);
    end
  endtask

  task automatic test_start_wins();
    int lat, bc; logic chg;
    mthi = 1'b1; wdata = 32'h77;
    @(posedge clk); #1;
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h55;
    run32(2'b00, 32'd2, 32'd3, lat, bc, chg);
    total++;
    if (chg !== 1'b0 || lat !== 34 || hi !== 32'h0 || lo !== 32'd6) begin
      bad++; $display("FAIL start_wins got chg=%b lat=%0d hi=%h lo=%h want 0 34 0 6", chg, lat, hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, seen; logic chg;
    mthi = 1'b1; wdata = 32'h99;
    @(posedge clk); #1;
    mthi = 1'b0;
    start = 1'b1; op = 2'b01; a = 32'hFFFFFFFD; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || seen !== 0) begin
      bad++; $display("FAIL reset_mid got busy=%b done=%b hi=%h lo=%h early=%0d want 0 0 0 0 0", busy, done, hi, lo, seen);
    end
    run32(2'b00, 32'd6, 32'd7, lat, bc, chg);
    total++;
    if (lat !== 34 || hi !== 32'h0 || lo !== 32'd42) begin
      bad++; $display("FAIL after_reset got lat=%0d hi=%h lo=%h want 34 0 0000002a", lat, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic chg;
    run32(2'b10, 32'd100, 32'd7, lat, bc, chg);
    total++;
    if (lat !== 34 || lo !== 32'd14 || hi !== 32'd2) begin
      bad++; $display("FAIL b2b_first got lat=%0d lo=%h hi=%h want 34 e 2", lat, lo, hi);
    end
    run32(2'b01, 32'hFFFFFFFD, 32'd7, lat, bc, chg);
    total++;
    if (lat !== 34 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
      bad++; $display("FAIL b2b_second got lat=%0d hi=%h lo=%h want 34 ffffffff ffffffeb", lat, hi, lo);
    end
  endtask

  task automatic test_width8();
    int lat, bc;
    run8(2'b00, 8'hFF, 8'hFF, lat, bc);
    total++;
    if (lat !== 10 || bc !== 9 || hi8 !== 8'hFE || lo8 !== 8'h01) begin
      bad++; $display("FAIL w8_multu got lat=%0d busycycles=%0d hi=%h lo=%h want 10 9 fe 01", lat, bc, hi8, lo8);
    end
    run8(2'b11, 8'hF9, 8'h02, lat, bc);
    total++;
    if (lat !== 10 || lo8 !== 8'hFD || hi8 !== 8'hFF) begin
      bad++; $display("FAIL w8_div got lat=%0d lo=%h hi=%h want 10 fd ff", lat, lo8, hi8);
    end
    run8(2'b11, 8'h80, 8'hFF, lat, bc);
    total++;
    if (lo8 !== 8'h80 || hi8 !== 8'h00 || dbz8 !== 1'b0) begin
      bad++; $display("FAIL w8_div_ovf got lo=%h hi=%h dbz=%b want 80 00 0", lo8, hi8, dbz8);
    end
  endtask

  initial begin
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0; op = 2'b00; a = '0; b = '0; wdata = '0;
    start8 = 1'b0; mthi8 = 1'b0; mtlo8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0; wdata8 = '0;
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_by_zero();
    test_mthi_mtlo();
    test_start_wins();
    test_reset_mid();
    test_back_to_back();
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
